// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Used by the winner picker, the data mux and the arbiter top.
package rr_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8n.sv
// 8:1 N-bit data mux.
// Requester i occupies in_data[i*N +: N].
module mux8n
    import rr_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [NUM_REQ*N-1:0] in_data,
    input  logic [SEL_W-1:0]     sel,
    output logic [N-1:0]         out_data
);

    assign out_data = in_data[sel*N +: N];

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: returns the first set req bit,
// scanning ptr, ptr+1, ... ptr+7 (mod 8).
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W-1:0] cand;

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Scan from the farthest offset down so the closest set bit wins last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one N-bit channel among 8 requesters.
// Supports locked bursts of up to MAX_BURST beats per grant.
module rr_mux8_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   lock,
    input  logic [NUM_REQ*N-1:0] in_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [SEL_W-1:0]     sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [SEL_W-1:0]     out_src
);

    localparam int              CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic               granted, accept, abandon, hold, rel;
    logic [SEL_W-1:0]   pick_ptr, pick_idx;
    logic               pick_found;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    mux8n #(.N(N)) u_mux (
        .in_data  (in_data),
        .sel      (sel_q),
        .out_data (out_data)
    );

    always_comb begin
        granted   = (state_q == GRANT);
        out_valid = granted & req[sel_q];
        accept    = out_valid & out_ready;
        abandon   = granted & ~req[sel_q];
        hold      = accept & lock[sel_q] & (cnt_q < LAST_BEAT);
        rel       = abandon | (accept & ~hold);
        // On release the new winner is picked against the already-advanced pointer.
        pick_ptr  = rel ? sel_q + SEL_W'(1) : ptr_q;

        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    grant_d = onehot(pick_idx);
                end
            end
            GRANT: begin
                if (hold) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (rel) begin
                    ptr_d = pick_ptr;
                    cnt_d = '0;
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        grant_d = onehot(pick_idx);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign out_src = sel_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Scoreboard bench for rr_mux8_arbiter: stimulus pushes model predictions,
// a negedge monitor pops and compares them against the DUT.
module tb_rr_mux8_arbiter;

    localparam int N    = 8;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req, lock, grant;
    logic [63:0] in_data;
    logic [2:0]  sel, out_src;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] grant;
        int         sel;
        logic       valid;
        logic [7:0] data;
    } cyc_t;

    typedef struct {
        int         src;
        logic [7:0] data;
    } beat_t;

    cyc_t  cyc_q[$];
    beat_t beat_q[$];

    // Reference model: current owner (-1 = idle), rotation pointer, beats taken in burst.
    int m_cur = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    rr_mux8_arbiter #(.N(N), .MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .in_data   (in_data),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic int first_req(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, record what the DUT must show, then advance the model.
    task automatic apply(input logic [7:0] r, input logic [7:0] l, input logic rdy,
                         input logic [63:0] d);
        cyc_t e;
        bit   rel;
        req       = r;
        lock      = l;
        out_ready = rdy;
        in_data   = d;

        e.grant = (m_cur < 0) ? 8'h00 : 8'(1 << m_cur);
        e.sel   = m_cur;
        e.valid = (m_cur >= 0) && r[m_cur];
        e.data  = e.valid ? d[m_cur*N +: N] : 8'h00;
        cyc_q.push_back(e);
        if (e.valid && rdy) beat_q.push_back('{m_cur, d[m_cur*N +: N]});

        if (m_cur < 0) begin
            m_cur = first_req(r, m_ptr);
        end else begin
            rel = 1'b0;
            if (!r[m_cur]) rel = 1'b1;
            else if (rdy) begin
                if (l[m_cur] && m_cnt < MAXB - 1) m_cnt++;
                else rel = 1'b1;
            end
            if (rel) begin
                m_ptr = (m_cur + 1) % 8;
                m_cnt = 0;
                m_cur = first_req(r, m_ptr);
            end
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic rdy,
                         input logic [63:0] d);
        @(posedge clk);
        #1;
        apply(r, l, rdy, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 8'h00, 1'b1, rnd64());
    endtask

    // Asynchronous reset pulse between clock edges, released just after the next edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", grant, 0);
        check("async_rst_valid", out_valid, 0);
        m_cur = -1;
        m_ptr = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(req, 8'h00, 1'b1, rnd64());
    endtask

    always @(negedge clk) begin
        cyc_t  e;
        beat_t b;
        if (rst_n) begin
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("grant", grant, e.grant);
                check("out_valid", out_valid, e.valid);
                if (e.grant != 0) begin
                    check("sel", sel, e.sel);
                    check("out_src", out_src, e.sel);
                end
                if (e.valid) check("out_data", out_data, e.data);
            end
            if (out_valid && out_ready) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got beat from src %0d expected none at %0t",
                             out_src, $time);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_src", out_src, b.src);
                    check("beat_data", out_data, b.data);
                end
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  r;

        rst_n     = 1'b0;
        req       = 8'h00;
        lock      = 8'h00;
        out_ready = 1'b0;
        d         = rnd64();
        in_data   = d;
        #1;
        check("rst_grant", grant, 0);
        check("rst_sel", sel, 0);
        check("rst_valid", out_valid, 0);
        check("rst_out_data", out_data, d[7:0]);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(8'h00, 8'h00, 1'b1, rnd64());

        // Single request on 2: one-cycle grant latency, one beat, then idle.
        repeat (2) drive(8'h04, 8'h00, 1'b1, rnd64());
        idle(2);

        // All requesting: strict rotation with no idle bubble.
        repeat (17) drive(8'hFF, 8'h00, 1'b1, rnd64());
        idle(2);

        // Locked burst on 0 capped at MAXB beats, then 1 gets the channel.
        repeat (8) drive(8'h03, 8'h01, 1'b1, rnd64());
        idle(2);

        // Backpressure: beat on 4 held through five stalled cycles.
        d = rnd64();
        d[39:32] = 8'hA5;
        repeat (6) drive(8'h10, 8'h00, 1'b0, d);
        drive(8'h10, 8'h00, 1'b1, d);
        idle(2);

        // Abandon on 6 moves to 7, then abandon on 6 wraps to 0.
        drive(8'hC0, 8'h00, 1'b0, rnd64());
        drive(8'h80, 8'h00, 1'b0, rnd64());
        drive(8'h80, 8'h00, 1'b1, rnd64());
        idle(1);
        drive(8'h40, 8'h00, 1'b0, rnd64());
        drive(8'h01, 8'h00, 1'b0, rnd64());
        drive(8'h01, 8'h00, 1'b1, rnd64());
        idle(2);

        // Reset lands during beat 2 of a locked burst.
        repeat (3) drive(8'h01, 8'h01, 1'b1, rnd64());
        pulse_reset();
        drive(8'h01, 8'h00, 1'b1, rnd64());
        idle(2);

        // Random traffic with random locks, backpressure and abandons.
        for (int i = 0; i < 600; i++) begin
            r = 8'($urandom());
            if ($urandom_range(0, 1) == 0) r = r & 8'($urandom());
            drive(r, 8'($urandom()), ($urandom_range(0, 9) < 7), rnd64());
        end
        idle(3);

        @(negedge clk);
        #1;
        check("beat_q_drained", beat_q.size(), 0);
        check("cyc_q_drained", cyc_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
